pwm_ramp_sequencer: RTL and testbench

- Slew-rate-limited duty/direction controller that sits between rover command logic and the 10-step PWM generator.
- Accepts target (duty, direction) commands over a valid/ready handshake. Ramps the PWM duty one step at a time at a programmable rate.
- On direction reversal: ramps to zero, holds a dead-time, flips direction, then ramps back up.
- Provides an emergency stop that forces duty to zero immediately.

---
 rtl/pwm_ramp_sequencer.sv | 118 +++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// Slew-rate-limited duty/direction sequencer feeding the 10-step PWM generator.
// Ramps duty one step per STEP_DIV cycles; reversals brake to zero and hold a dead-time.
module pwm_ramp_sequencer #(
   parameter int unsigned DUTY_W   = 4,
   parameter int unsigned MAX_DUTY = 10,
   parameter int unsigned STEP_DIV = 2500000,
   parameter int unsigned DEADTIME = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_duty,
   input  logic              cmd_dir,
   input  logic              estop,
   output logic [DUTY_W-1:0] duty,
   output logic              dir,
   output logic              busy,
   output logic              at_target
);

   localparam int unsigned STEP_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(MAX_DUTY);

   typedef enum logic [1:0] {StIdle, StRamp, StBrake, StDead} state_e;

   state_e              r_state;
   logic [DUTY_W-1:0]   r_duty;
   logic                r_dir;
   logic [DUTY_W-1:0]   r_tgt;
   logic                r_tgt_dir;
   logic [STEP_W-1:0]   r_step_cnt;
   logic [DEAD_W-1:0]   r_dead_cnt;

   logic                w_accept;
   logic [DUTY_W-1:0]   w_cmd_tgt;
   logic [DUTY_W-1:0]   w_ramp_next;
   logic                w_step_fire;
   logic                w_dead_fire;

   assign cmd_ready   = (r_state == StIdle) && !estop;
   assign w_accept    = cmd_valid && cmd_ready;
   assign w_cmd_tgt   = (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;
   assign w_step_fire = (r_step_cnt == STEP_LAST);
   assign w_dead_fire = (r_dead_cnt == DEAD_LAST);
   assign w_ramp_next = (r_duty < r_tgt) ? r_duty + 1'b1 :
                        (r_duty > r_tgt) ? r_duty - 1'b1 : r_duty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_duty     <= '0;
         r_dir      <= 1'b0;
         r_tgt      <= '0;
         r_tgt_dir  <= 1'b0;
         r_step_cnt <= '0;
         r_dead_cnt <= '0;
      end else if (estop) begin
         // Direction is deliberately kept so the motor driver never sees a glitch.
         r_state <= StIdle;
         r_duty  <= '0;
         r_tgt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_tgt      <= w_cmd_tgt;
                  r_tgt_dir  <= cmd_dir;
                  r_step_cnt <= '0;
                  r_dead_cnt <= '0;
                  if (cmd_dir == r_dir) begin
                     if (w_cmd_tgt != r_duty) r_state <= StRamp;
                  end else if (r_duty != '0) begin
                     r_state <= StBrake;
                  end else begin
                     r_state <= StDead;
                  end
               end
            end
            StRamp: begin
               r_step_cnt <= w_step_fire ? '0 : r_step_cnt + 1'b1;
               if (w_step_fire) begin
                  r_duty <= w_ramp_next;
                  if (w_ramp_next == r_tgt) r_state <= StIdle;
               end
            end
            StBrake: begin
               r_step_cnt <= w_step_fire ? '0 : r_step_cnt + 1'b1;
               if (w_step_fire) begin
                  r_duty <= (r_duty != '0) ? r_duty - 1'b1 : '0;
                  if (r_duty <= DUTY_W'(1)) begin
                     r_state    <= StDead;
                     r_dead_cnt <= '0;
                  end
               end
            end
            StDead: begin
               r_dead_cnt <= r_dead_cnt + 1'b1;
               if (w_dead_fire) begin
                  r_dir      <= r_tgt_dir;
                  r_step_cnt <= '0;
                  r_state    <= (r_tgt == '0) ? StIdle : StRamp;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign duty      = r_duty;
   assign dir       = r_dir;
   assign busy      = (r_state != StIdle);
   assign at_target = (r_duty == r_tgt) && (r_dir == r_tgt_dir);

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench: the driver pushes one expected snapshot per clock edge from a
// trajectory model; a monitor pops and compares one snapshot after every edge.
module tb_pwm_ramp_sequencer;

   localparam int SD   = 4;
   localparam int DT   = 3;
   localparam int MAXD = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_duty = '0;
   logic       cmd_dir = 1'b0;
   logic       estop = 1'b0;
   logic [3:0] duty;
   logic       dir;
   logic       busy;
   logic       at_target;

   pwm_ramp_sequencer #(
      .DUTY_W   (4),
      .MAX_DUTY (MAXD),
      .STEP_DIV (SD),
      .DEADTIME (DT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_duty  (cmd_duty),
      .cmd_dir   (cmd_dir),
      .estop     (estop),
      .duty      (duty),
      .dir       (dir),
      .busy      (busy),
      .at_target (at_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      int duty;
      bit dir;
      bit busy;
      bit at_tgt;
      bit ready;
   } exp_t;

   typedef struct {
      int duty;
      bit dir;
      bit busy;
   } traj_t;

   exp_t  sb[$];
   traj_t traj[$];
   exp_t  me;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int m_duty    = 0;
   bit m_dir     = 1'b0;
   int m_tgt     = 0;
   bit m_tgt_dir = 1'b0;

   int prev_duty    = 0;
   bit prev_dir     = 1'b0;
   bit prev_started = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
      end
   endtask

   // Monitor: one expected snapshot per edge while the scoreboard holds entries.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (sb.size() > 0) begin
         me = sb.pop_front();
         chk("duty", int'(duty), me.duty);
         chk("dir", int'(dir), int'(me.dir));
         chk("busy", int'(busy), int'(me.busy));
         chk("at_target", int'(at_target), int'(me.at_tgt));
         chk("cmd_ready", int'(cmd_ready), int'(me.ready));
      end
      if (prev_started && !rst && (dir != prev_dir))
         chk("dir_change_at_nonzero_duty", prev_duty, 0);
      prev_duty    = int'(duty);
      prev_dir     = dir;
      prev_started = 1'b1;
   end

   // Push the expectation for the coming edge, then wait until after it.
   task automatic step(input int du, input bit di, input bit bu);
      exp_t e;
      e.duty   = du;
      e.dir    = di;
      e.busy   = bu;
      e.at_tgt = (du == m_tgt) && (di == m_tgt_dir);
      e.ready  = !bu && !estop;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Per-edge trajectory of an accepted command, edge 0 being the accept edge.
   task automatic build_traj(input int t, input bit r);
      int n, sg, b;
      traj.delete();
      if (r == m_dir) begin
         n  = (t > m_duty) ? t - m_duty : m_duty - t;
         sg = (t > m_duty) ? 1 : -1;
         if (n == 0) traj.push_back(traj_t'{m_duty, m_dir, 1'b0});
         else
            for (int e = 0; e <= SD * n; e++)
               traj.push_back(traj_t'{m_duty + sg * (e / SD), m_dir, e < SD * n});
      end else begin
         b = m_duty;
         for (int e = 0; e < SD * b + DT; e++)
            traj.push_back(traj_t'{b - ((e < SD * b) ? e / SD : b), m_dir, 1'b1});
         for (int k = 0; k <= SD * t; k++)
            traj.push_back(traj_t'{k / SD, r, k < SD * t});
      end
   endtask

   // kind: 0 none, 1 estop, 2 rst; abort lands on edge abort_at of the sequence.
   task automatic run_cmd(input int d, input bit r, input int abort_at, input int kind);
      int t, lim, hold;
      t = (d > MAXD) ? MAXD : d;
      build_traj(t, r);
      m_tgt     = t;
      m_tgt_dir = r;
      lim = (kind != 0 && abort_at >= 1 && abort_at < traj.size()) ? abort_at : traj.size();
      cmd_valid = 1'b1;
      cmd_duty  = 4'(d);
      cmd_dir   = r;
      for (int i = 0; i < lim; i++) begin
         step(traj[i].duty, traj[i].dir, traj[i].busy);
         cmd_valid = 1'b0;
      end
      m_duty = traj[lim-1].duty;
      m_dir  = traj[lim-1].dir;
      if (lim < traj.size()) begin
         if (kind == 1) begin
            estop  = 1'b1;
            m_duty = 0;
            m_tgt  = 0;
            hold   = int'($urandom_range(1, 4));
            for (int h = 0; h < hold; h++) begin
               if (h == hold - 1) begin
                  cmd_valid = 1'b1;
                  cmd_duty  = 4'($urandom_range(1, 15));
                  cmd_dir   = 1'($urandom_range(0, 1));
               end
               step(0, m_dir, 1'b0);
               cmd_valid = 1'b0;
            end
            estop = 1'b0;
            step(0, m_dir, 1'b0);
         end else begin
            rst       = 1'b1;
            m_duty    = 0;
            m_dir     = 1'b0;
            m_tgt     = 0;
            m_tgt_dir = 1'b0;
            step(0, 1'b0, 1'b0);
            rst = 1'b0;
         end
      end
   endtask

   initial begin
      int d, x, kind, ab;
      bit r;
      @(negedge clk);
      step(0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0);
      rst = 1'b0;
      step(0, 1'b0, 1'b0);

      run_cmd(3, 1'b0, 0, 0);
      run_cmd(2, 1'b0, 0, 0);
      run_cmd(1, 1'b1, 0, 0);
      run_cmd(9, 1'b1, 0, 0);
      run_cmd(15, 1'b1, 0, 0);
      run_cmd(0, 1'b1, 0, 0);
      run_cmd(5, 1'b1, 6, 1);
      run_cmd(6, 1'b1, 0, 0);
      run_cmd(2, 1'b0, 5, 2);
      run_cmd(0, 1'b0, 0, 0);
      run_cmd(4, 1'b0, 0, 0);
      run_cmd(4, 1'b0, 0, 0);
      run_cmd(0, 1'b1, 0, 0);
      run_cmd(13, 1'b0, 0, 0);

      for (int it = 0; it < 40; it++) begin
         d    = int'($urandom_range(0, 15));
         r    = 1'($urandom_range(0, 1));
         x    = int'($urandom_range(0, 9));
         kind = (x == 0) ? 1 : (x == 1) ? 2 : 0;
         ab   = int'($urandom_range(1, 40));
         run_cmd(d, r, ab, kind);
         repeat ($urandom_range(0, 2)) step(m_duty, m_dir, 1'b0);
      end

      @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
